serial_negate_ctrl: RTL and testbench

Word-level controller that sequences a bit-serial two's-complement engine. It accepts a parallel word over a valid/ready handshake and shifts it LSB-first through an internal serial complement stage: bits pass unchanged up to and including the first 1, and every later bit is inverted. It reassembles the result and presents it on an output valid/ready handshake. The block sits between a parallel producer and consumer, so the serial engine can be used as a drop-in negation resource.

---
 rtl/serial_negate_ctrl_if.sv | 25 ++
 rtl/serial_negate_ctrl.sv | 110 +++++++++++
 tb/tb_serial_negate_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_negate_ctrl_if.sv
// Word-level handshake bundle for the serial negation controller:
// producer side (in_*, din, mode), consumer side (out_*, dout, ovf) and status.
interface serial_negate_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] din;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] dout;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, din, mode, out_ready,
      input  in_ready, out_valid, dout, ovf, busy
   );

   modport slave (
      input  in_valid, din, mode, out_ready,
      output in_ready, out_valid, dout, ovf, busy
   );
endinterface

// File: rtl/serial_negate_ctrl.sv
// Accepts a parallel word, pushes it LSB-first through a serial two's-complement
// stage (copy through the first 1, invert afterwards) and returns the word.
module serial_negate_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   serial_negate_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             seen_one_q, seen_one_d;
   logic             mode_q, mode_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             obit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sreg_q     <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         seen_one_q <= 1'b0;
         mode_q     <= 1'b0;
         ovf_pend_q <= 1'b0;
         dout_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         res_q      <= res_d;
         cnt_q      <= cnt_d;
         seen_one_q <= seen_one_d;
         mode_q     <= mode_d;
         ovf_pend_q <= ovf_pend_d;
         dout_q     <= dout_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      res_d       = res_q;
      cnt_d       = cnt_q;
      seen_one_d  = seen_one_q;
      mode_d      = mode_q;
      ovf_pend_d  = ovf_pend_q;
      dout_d      = dout_q;
      ovf_d       = ovf_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      obit        = (mode_q && seen_one_q) ? ~sreg_q[0] : sreg_q[0];

      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            // din/mode are only looked at when the producer qualifies them
            if (bus.in_valid) begin
               sreg_d     = bus.din;
               mode_d     = bus.mode;
               cnt_d      = '0;
               seen_one_d = 1'b0;
               res_d      = '0;
               ovf_pend_d = bus.mode && (bus.din == MOST_NEG);
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            res_d      = {obit, res_q[WIDTH-1:1]};
            sreg_d     = sreg_q >> 1;
            seen_one_d = seen_one_q | sreg_q[0];
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // Publish the finished word; dout/ovf then hold until the next one.
               dout_d  = res_d;
               ovf_d   = ovf_pend_q;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.dout      = dout_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Scoreboard bench for serial_negate_ctrl: expected words are queued at accept
// time from a negation model and compared when the consumer handshake completes.
module tb_serial_negate_ctrl;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] dout;
      logic             ovf;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   exp_t sb[$];
   int   cyc;
   int   acc_cyc;
   bit   acc_valid;
   int   acc_count;
   bit   prev_ov;
   bit   prev_hs;
   bit   b2b_en;
   bit   b2b_have;
   int   b2b_last;

   serial_negate_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_negate_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] d, input logic m);
      exp_t e;
      e.dout = m ? (WIDTH'(0) - d) : d;
      e.ovf  = m && (d == 8'h80);
      return e;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      bit   hs;
      exp_t e;
      cyc++;
      if (rst) begin
         sb.delete();
         acc_valid = 1'b0;
         prev_ov   = 1'b0;
         prev_hs   = 1'b0;
      end else begin
         hs = bus.out_valid && bus.out_ready;
         if (prev_hs) chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
         if (bus.out_valid && !prev_ov) begin
            if (acc_valid) chk("latency", 32'(cyc - acc_cyc), 32'd9);
            else           chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            acc_valid = 1'b0;
         end
         if (hs) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               $display("txn out: dout=%02h ovf=%0b (expect %02h/%0b)", bus.dout, bus.ovf, e.dout, e.ovf);
               chk("dout", 32'(bus.dout), 32'(e.dout));
               chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            $display("txn in : din=%02h mode=%0b", bus.din, bus.mode);
            sb.push_back(model(bus.din, bus.mode));
            if (b2b_en) begin
               if (b2b_have) chk("accept_spacing", 32'(cyc - b2b_last), 32'd10);
               b2b_have = 1'b1;
               b2b_last = cyc;
            end
            acc_cyc   = cyc;
            acc_valid = 1'b1;
            acc_count++;
         end
         prev_ov = bus.out_valid;
         prev_hs = hs;
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [WIDTH-1:0] d, input logic m, input bit keep);
      bit ok;
      ok           = 1'b0;
      bus.in_valid = 1'b1;
      bus.din      = d;
      bus.mode     = m;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (!keep) begin
         bus.in_valid = 1'b0;
         bus.din      = WIDTH'($urandom);
         bus.mode     = 1'($urandom);
      end
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] dvec [5];
      logic       mvec [5];
      int         acc_before;
      bit         seen;
      errors = 0; checks = 0; cyc = 0; acc_count = 0;
      b2b_en = 1'b0; b2b_have = 1'b0;
      dvec = '{8'h05, 8'h00, 8'h80, 8'hFF, 8'hA5};
      mvec = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.din = '0; bus.mode = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_dout", 32'(bus.dout), 32'd0);
      chk("rst_ovf", 32'(bus.ovf), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed words: plain negate, zero, most-negative, all-ones, pass-through.
      for (int i = 0; i < 5; i++) begin
         send(dvec[i], mvec[i], 1'b0);
         drain();
      end

      // Backpressure with a producer holding in_valid during SHIFT/DONE.
      bus.out_ready = 1'b0;
      send(8'h5A, 1'b1, 1'b0);
      bus.in_valid = 1'b1; bus.din = 8'h3C; bus.mode = 1'b1;
      acc_before = acc_count;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_out_valid_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_dout_hold", 32'(bus.dout), 32'h0A6);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_busy", 32'(bus.busy), 32'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp_accepts", 32'(acc_count - acc_before), 32'd1);
      drain();

      // Reset after three bits of 0x12 discards the word.
      send(8'h12, 1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #1;
      send(8'h12, 1'b1, 1'b0);
      drain();

      // Back-to-back random words with in_valid and out_ready held high.
      b2b_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         send(WIDTH'($urandom), 1'($urandom), i < 99);
      end
      b2b_en = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
